// File: rtl/path_pkg.sv
// Shared definitions for the shortest-path solver and the path tracer.
// Contents: direction codes written into P, default data/address widths,
// and the tracer FSM state encoding.
package path_pkg;

  localparam int unsigned PKG_D_WIDTH = 8;
  localparam int unsigned PKG_A_WIDTH = 16;

  // Direction codes: how the cost front reached each cell
  localparam logic [7:0] DIR_START = 8'h08;
  localparam logic [7:0] DIR_RIGHT = 8'h09;
  localparam logic [7:0] DIR_DOWN  = 8'h0A;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CAPT  = 3'd3,
    ST_STEP  = 3'd4
  } state_t;

endpackage

// File: rtl/path_tracer.sv
// Reconstructs the minimum-cost route from direction memory P.
// It walks P backwards from (NUM_ROWS-1, NUM_COLS-1) to (0,0) and writes R[i+j] = i*NUM_COLS+j.
// Malformed P contents end the walk with Done and Err instead of hanging.
// Ports:
//   Clk, Rst         clock and synchronous active-high reset
//   Go               start request, sampled only in IDLE
//   P_In             P read data
//   P_Addr/En/Rw     P read port (Rw always 0)
//   R_Out/Addr/En/Rw R write port (Rw = 1 on write)
//   Done, Err        one-cycle completion / fault pulses
module path_tracer
  import path_pkg::*;
#(
  parameter int unsigned NUM_ROWS = 4,
  parameter int unsigned NUM_COLS = 4,
  parameter int unsigned D_WIDTH  = PKG_D_WIDTH,
  parameter int unsigned A_WIDTH  = PKG_A_WIDTH
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Go,
  input  logic [D_WIDTH-1:0] P_In,
  output logic [A_WIDTH-1:0] P_Addr,
  output logic               P_En,
  output logic               P_Rw,
  output logic [D_WIDTH-1:0] R_Out,
  output logic [A_WIDTH-1:0] R_Addr,
  output logic               R_En,
  output logic               R_Rw,
  output logic               Done,
  output logic               Err
);

  localparam int unsigned I_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int unsigned J_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam logic [I_W-1:0] I_MAX = I_W'(NUM_ROWS - 1);
  localparam logic [J_W-1:0] J_MAX = J_W'(NUM_COLS - 1);

  state_t             r_state, w_state_nxt;
  logic [I_W-1:0]     r_i, w_i_nxt;
  logic [J_W-1:0]     r_j, w_j_nxt;
  logic [D_WIDTH-1:0] r_p_reg, w_p_reg_nxt;

  logic [A_WIDTH-1:0] r_p_addr, w_p_addr;
  logic               r_p_en, w_p_en;
  logic [D_WIDTH-1:0] r_r_out, w_r_out;
  logic [A_WIDTH-1:0] r_r_addr, w_r_addr;
  logic               r_r_en, w_r_en;
  logic               r_done, w_done;
  logic               r_err, w_err;

  logic [A_WIDTH-1:0] w_cell_addr;
  logic [A_WIDTH-1:0] w_route_idx;
  logic               w_fin, w_go_right, w_go_down, w_step_ok;

  // Cell address into P and route index into R
  assign w_cell_addr = A_WIDTH'(r_i) * A_WIDTH'(NUM_COLS) + A_WIDTH'(r_j);
  assign w_route_idx = A_WIDTH'(r_i) + A_WIDTH'(r_j);

  // Decode of the captured direction; a legal step must stay inside the grid
  assign w_fin      = (r_p_reg == D_WIDTH'(DIR_START)) && (r_i == '0) && (r_j == '0);
  assign w_go_right = (r_p_reg == D_WIDTH'(DIR_RIGHT)) && (r_j != '0);
  assign w_go_down  = (r_p_reg == D_WIDTH'(DIR_DOWN))  && (r_i != '0);
  assign w_step_ok  = w_fin || w_go_right || w_go_down;

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (Go) w_state_nxt = ST_ISSUE;
      ST_ISSUE: w_state_nxt = ST_WAIT;
      ST_WAIT:  w_state_nxt = ST_CAPT;
      ST_CAPT:  w_state_nxt = ST_STEP;
      ST_STEP:  w_state_nxt = (w_go_right || w_go_down) ? ST_ISSUE : ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Output and datapath next values; every strobe defaults low
  always_comb begin
    w_i_nxt     = r_i;
    w_j_nxt     = r_j;
    w_p_reg_nxt = r_p_reg;
    w_p_addr    = '0;
    w_p_en      = 1'b0;
    w_r_out     = '0;
    w_r_addr    = '0;
    w_r_en      = 1'b0;
    w_done      = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (Go) begin
          w_i_nxt = I_MAX;
          w_j_nxt = J_MAX;
        end
      end
      ST_ISSUE: begin
        w_p_en   = 1'b1;
        w_p_addr = w_cell_addr;
      end
      ST_CAPT: begin
        w_p_reg_nxt = P_In;
      end
      ST_STEP: begin
        if (w_step_ok) begin
          // Route entry uses the coordinates before the step
          w_r_en   = 1'b1;
          w_r_addr = w_route_idx;
          w_r_out  = D_WIDTH'(w_cell_addr);
          if (w_fin)      w_done  = 1'b1;
          if (w_go_right) w_j_nxt = r_j - J_W'(1);
          if (w_go_down)  w_i_nxt = r_i - I_W'(1);
        end else begin
          w_done = 1'b1;
          w_err  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_i      <= '0;
      r_j      <= '0;
      r_p_reg  <= '0;
      r_p_addr <= '0;
      r_p_en   <= 1'b0;
      r_r_out  <= '0;
      r_r_addr <= '0;
      r_r_en   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_i      <= w_i_nxt;
      r_j      <= w_j_nxt;
      r_p_reg  <= w_p_reg_nxt;
      r_p_addr <= w_p_addr;
      r_p_en   <= w_p_en;
      r_r_out  <= w_r_out;
      r_r_addr <= w_r_addr;
      r_r_en   <= w_r_en;
      r_done   <= w_done;
      r_err    <= w_err;
    end
  end

  assign P_Addr = r_p_addr;
  assign P_En   = r_p_en;
  assign P_Rw   = 1'b0;
  assign R_Out  = r_r_out;
  assign R_Addr = r_r_addr;
  assign R_En   = r_r_en;
  assign R_Rw   = r_r_en;
  assign Done   = r_done;
  assign Err    = r_err;

endmodule

// File: tb/tb_path_tracer.sv
// Scoreboard bench for path_tracer: expected P reads and R writes are queued
// when a scenario starts and compared as the DUT strobes them.
module tb_path_tracer;

  logic        clk;
  logic        rst;
  logic        go;
  logic [7:0]  p_in;
  logic [15:0] p_addr;
  logic        p_en;
  logic        p_rw;
  logic [7:0]  r_out;
  logic [15:0] r_addr;
  logic        r_en;
  logic        r_rw;
  logic        done;
  logic        err;

  path_tracer dut (
    .Clk(clk), .Rst(rst), .Go(go), .P_In(p_in),
    .P_Addr(p_addr), .P_En(p_en), .P_Rw(p_rw),
    .R_Out(r_out), .R_Addr(r_addr), .R_En(r_en), .R_Rw(r_rw),
    .Done(done), .Err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] pmem [16];
  logic [7:0] rmem [16];
  logic [7:0] p_dout = 8'h00;

  int p_q[$];
  int ra_q[$];
  int rd_q[$];

  // Cells on the scenario-1 route, in visit order (15 first)
  int S1_P[7] = '{15, 14, 13, 12, 8, 4, 0};
  int S2_P[7] = '{15, 11, 7, 3, 2, 1, 0};

  assign p_in = p_dout;

  // P memory: data registered at the edge after the strobe, held until next read
  always @(posedge clk) if (p_en === 1'b1) p_dout <= pmem[p_addr[3:0]];
  always @(posedge clk) if (r_en === 1'b1 && r_rw === 1'b1) rmem[r_addr[3:0]] <= r_out;

  function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (p_en === 1'b1) begin
      chk("p_rw", 32'(p_rw), 32'd0);
      chk("p_read_expected", 32'(p_q.size() != 0), 32'd1);
      if (p_q.size() != 0) chk("p_addr", 32'(p_addr), 32'(p_q.pop_front()));
    end
    if (r_en === 1'b1) begin
      chk("r_rw", 32'(r_rw), 32'd1);
      chk("r_write_expected", 32'(ra_q.size() != 0), 32'd1);
      if (ra_q.size() != 0) begin
        chk("r_addr", 32'(r_addr), 32'(ra_q.pop_front()));
        chk("r_out", 32'(r_out), 32'(rd_q.pop_front()));
      end
    end
    if (err === 1'b1) chk("err_with_done", 32'(done), 32'd1);
  end

  task automatic fill_s1();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (i == 0 && j == 0) pmem[i*4+j] = 8'h08;
        else if (j == 0)      pmem[i*4+j] = 8'h0A;
        else                  pmem[i*4+j] = 8'h09;
  endtask

  task automatic fill_s2();
    for (int k = 0; k < 16; k++) pmem[k] = 8'h00;
    pmem[15] = 8'h0A; pmem[11] = 8'h0A; pmem[7] = 8'h0A;
    pmem[3]  = 8'h09; pmem[2]  = 8'h09; pmem[1] = 8'h09;
    pmem[0]  = 8'h08;
  endtask

  task automatic push_route(input int np, input int nr, input bit use_s2);
    for (int k = 0; k < np; k++) p_q.push_back(use_s2 ? S2_P[k] : S1_P[k]);
    for (int k = 0; k < nr; k++) begin
      ra_q.push_back(6 - k);
      rd_q.push_back(use_s2 ? S2_P[k] : S1_P[k]);
    end
  endtask

  // Go is high at edge e0, at edges e0+1..e0+hold-1, and at edge e0+repulse
  task automatic run(input string tag, input int hold, input int repulse,
                     input int exp_edges, input logic exp_err);
    int n;
    @(negedge clk); go = 1'b1;
    @(posedge clk);
    n = 0;
    while (1) begin
      @(negedge clk);
      if (n > 0 && done === 1'b1) break;
      go = (n + 1 < hold) || (n + 1 == repulse);
      if (n >= 200) break;
      @(posedge clk); n++;
    end
    go = 1'b0;
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
    chk({tag, "_done_edge"}, 32'(n), 32'(exp_edges));
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'({done, err}), 32'd0);
  endtask

  task automatic drain(input string tag);
    repeat (12) @(negedge clk);
    chk({tag, "_p_q_empty"}, 32'(p_q.size()), 32'd0);
    chk({tag, "_r_q_empty"}, 32'(ra_q.size()), 32'd0);
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_p_addr"}, 32'(p_addr), 32'd0);
    chk({tag, "_r_addr"}, 32'(r_addr), 32'd0);
    chk({tag, "_ctl"}, 32'({r_out, p_en, p_rw, r_en, r_rw, done, err}), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    go  = 1'b0;
    fill_s1();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_outs_zero("reset");
    rst = 1'b0;

    // 1: row 0 Right, col 0 Down, interior Right
    push_route(7, 7, 1'b0);
    run("s1", 1, -1, 28, 1'b0);
    drain("s1");
    for (int k = 0; k < 7; k++) chk("s1_rmem", 32'(rmem[6-k]), 32'(S1_P[k]));

    // 2: down the right edge, then right along row 0
    fill_s2();
    push_route(7, 7, 1'b1);
    run("s2", 1, -1, 28, 1'b0);
    drain("s2");
    for (int k = 0; k < 7; k++) chk("s2_rmem", 32'(rmem[6-k]), 32'(S2_P[k]));

    // 3: unknown code at the first cell
    pmem[15] = 8'h00;
    p_q.push_back(15);
    run("s3", 1, -1, 4, 1'b1);
    drain("s3");

    // 4: Right at column 0
    fill_s1();
    pmem[12] = 8'h09;
    push_route(4, 3, 1'b0);
    run("s4", 1, -1, 16, 1'b1);
    drain("s4");

    // 5: Go held, then re-pulsed mid-trace; only one trace
    fill_s1();
    push_route(7, 7, 1'b0);
    run("s5", 10, 15, 28, 1'b0);
    drain("s5");

    // 6: reset at edge e0+9, then a fresh trace
    push_route(2, 2, 1'b0);
    @(negedge clk); go = 1'b1;
    @(posedge clk);
    @(negedge clk); go = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_outs_zero("s6_reset");
    rst = 1'b0;
    drain("s6_abort");
    push_route(7, 7, 1'b0);
    run("s6", 1, -1, 28, 1'b0);
    drain("s6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
